// File: rtl/gpca_seq.sv
// gpca_seq: iterative multiply/divide sequencer.
// Two rows of the controlled add/subtract array are applied each RUN cycle,
// so a W-bit operation retires in W/2 cycles.
module gpca_seq #(
  parameter int unsigned W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             mode_i,
  input  logic [W-1:0]     a_i,
  input  logic [W-1:0]     b_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [2*W-1:0]   result_o,
  output logic             dbz_o
);

  localparam int unsigned HALF = W / 2;
  localparam int unsigned CW   = $clog2(HALF + 1);
  localparam int unsigned AW   = 2 * W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DZ   = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e            state_q, state_d;
  logic              mode_q, mode_d;
  logic [W-1:0]      opa_q, opa_d;   // multiplicand / dividend (shifts left in divide)
  logic [W-1:0]      opb_q, opb_d;   // multiplier (shifts right in multiply) / divisor
  logic [AW-1:0]     acc_q, acc_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [2*W-1:0]    result_q, result_d;
  logic              dbz_q, dbz_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;

  logic [AW-1:0]     mul_r0, mul_r1, div_r0, div_r1, acc_step;

  // One shift-add row: add multiplicand into the upper half when the bit is set, then shift right.
  function automatic logic [AW-1:0] mul_row(input logic [AW-1:0] acc,
                                             input logic [W-1:0]  mcand,
                                             input logic          mbit);
    logic [W:0] hi;
    hi = acc[2*W:W];
    if (mbit) begin
      hi = (W+1)'(acc[2*W-1:W]) + (W+1)'(mcand);
    end
    return {1'b0, hi, acc[W-1:1]};
  endfunction

  // One restoring row: shift in a dividend bit, trial-subtract the divisor,
  // and let the borrow select between keeping the difference and restoring.
  function automatic logic [AW-1:0] div_row(input logic [AW-1:0] acc,
                                             input logic          dbit,
                                             input logic [W-1:0]  dvsr);
    logic [W:0]   tmp;
    logic [W+1:0] diff;
    logic         sub_ok;
    logic [W-1:0] rem_n;
    tmp    = {acc[2*W-1:W], dbit};
    diff   = (W+2)'(tmp) - (W+2)'(dvsr);
    sub_ok = ~diff[W+1];
    rem_n  = sub_ok ? diff[W-1:0] : tmp[W-1:0];
    return {1'b0, rem_n, acc[W-2:0], sub_ok};
  endfunction

  // Two array rows evaluated combinationally per RUN cycle.
  always_comb begin
    mul_r0   = mul_row(acc_q,  opa_q, opb_q[0]);
    mul_r1   = mul_row(mul_r0, opa_q, opb_q[1]);
    div_r0   = div_row(acc_q,  opa_q[W-1], opb_q);
    div_r1   = div_row(div_r0, opa_q[W-2], opb_q);
    acc_step = mode_q ? div_r1 : mul_r1;
  end

  // Next-state, datapath and registered-output decode.
  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    opa_d    = opa_q;
    opb_d    = opb_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    dbz_d    = dbz_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start_i) begin
          mode_d  = mode_i;
          opa_d   = a_i;
          opb_d   = b_i;
          acc_d   = '0;
          cnt_d   = CW'(HALF);
          state_d = (mode_i && (b_i == '0)) ? S_DZ : S_RUN;
        end else if (state_q == S_DONE) begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        acc_d = acc_step;
        cnt_d = cnt_q - CW'(1);
        if (mode_q) begin
          opa_d = opa_q << 2;
        end else begin
          opb_d = opb_q >> 2;
        end
        if (cnt_q == CW'(1)) begin
          result_d = acc_step[2*W-1:0];
          dbz_d    = 1'b0;
          state_d  = S_DONE;
        end
      end
      S_DZ: begin
        result_d = {opa_q, {W{1'b1}}};
        dbz_d    = 1'b1;
        state_d  = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase

    busy_d = (state_d == S_RUN) || (state_d == S_DZ);
    done_d = (state_d == S_DONE);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      mode_q   <= 1'b0;
      opa_q    <= '0;
      opb_q    <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
      dbz_q    <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      opa_q    <= opa_d;
      opb_q    <= opb_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
      dbz_q    <= dbz_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign busy_o   = busy_q;
  assign done_o   = done_q;
  assign result_o = result_q;
  assign dbz_o    = dbz_q;

endmodule

// File: tb/tb_gpca_seq.sv
// Scoreboard bench for gpca_seq: expected {dbz, result} queued at launch, checked on done.
module tb_gpca_seq;

  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic           start_i;
  logic           mode_i;
  logic [W-1:0]   a_i;
  logic [W-1:0]   b_i;
  logic           busy_o;
  logic           done_o;
  logic [2*W-1:0] result_o;
  logic           dbz_o;

  int checks = 0;
  int errors = 0;
  logic [2*W:0] sb[$];

  gpca_seq #(.W(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .a_i      (a_i),
    .b_i      (b_i),
    .busy_o   (busy_o),
    .done_o   (done_o),
    .result_o (result_o),
    .dbz_o    (dbz_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference: {dbz, result}
  function automatic logic [2*W:0] model(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    logic [2*W-1:0] p;
    logic [W-1:0]   q, r;
    if (!m) begin
      p = (2*W)'(x) * (2*W)'(y);
      return {1'b0, p};
    end
    if (y == '0) return {1'b1, x, {W{1'b1}}};
    q = x / y;
    r = x % y;
    return {1'b0, r, q};
  endfunction

  // Pop and compare whenever the DUT signals completion.
  always @(negedge clk) begin
    logic [2*W:0] e;
    if (rst_n && done_o) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 64'(done_o), 64'(0));
      end else begin
        e = sb.pop_front();
        check("result", 64'(result_o), 64'(e[2*W-1:0]));
        check("dbz", 64'(dbz_o), 64'(e[2*W]));
      end
    end
  end

  // Called at a negedge: present a request, accept it on the next edge.
  task automatic launch(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    start_i = 1'b1;
    mode_i  = m;
    a_i     = x;
    b_i     = y;
    sb.push_back(model(m, x, y));
    @(posedge clk);
    #1;
    check("busy_rise", 64'(busy_o), 64'(1));
    start_i = 1'b0;
  endtask

  // Count negedges until done; returns at the negedge where done is seen.
  task automatic wait_done(input int exp_lat);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_o && k < 20);
    check("latency", 64'(k), 64'(exp_lat));
    check("busy_at_done", 64'(busy_o), 64'(0));
  endtask

  task automatic do_op(input logic m, input logic [W-1:0] x, input logic [W-1:0] y);
    launch(m, x, y);
    wait_done((m && y == '0) ? 2 : int'(W / 2) + 1);
    @(posedge clk);
    #1;
    check("done_fall", 64'(done_o), 64'(0));
    check("idle_busy", 64'(busy_o), 64'(0));
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n   = 1'b0;
    start_i = 1'b0;
    mode_i  = 1'b0;
    a_i     = '0;
    b_i     = '0;
    #1;
    check("rst_busy", 64'(busy_o), 64'(0));
    check("rst_done", 64'(done_o), 64'(0));
    check("rst_result", 64'(result_o), 64'(0));
    check("rst_dbz", 64'(dbz_o), 64'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed operations and edge values
    do_op(1'b0, 4'd13, 4'd11);
    do_op(1'b1, 4'd13, 4'd3);
    do_op(1'b1, 4'd15, 4'd0);
    do_op(1'b0, 4'd15, 4'd15);
    do_op(1'b0, 4'd0,  4'd9);
    do_op(1'b1, 4'd5,  4'd15);
    do_op(1'b1, 4'd15, 4'd1);

    // Start pulse mid-RUN is ignored
    start_i = 1'b1;
    mode_i  = 1'b0;
    a_i     = 4'd5;
    b_i     = 4'd3;
    sb.push_back(model(1'b0, 4'd5, 4'd3));
    @(posedge clk);
    #1;
    start_i = 1'b0;
    @(negedge clk);
    start_i = 1'b1;
    mode_i  = 1'b1;
    a_i     = 4'd9;
    b_i     = 4'd0;
    @(posedge clk);
    #1;
    start_i = 1'b0;
    wait_done(int'(W / 2));
    repeat (4) @(negedge clk);
    check("ignored_idle", 64'(busy_o), 64'(0));

    // Back-to-back: launch the next op in the DONE cycle
    launch(1'b0, 4'd2, 4'd3);
    wait_done(int'(W / 2) + 1);
    launch(1'b0, 4'd7, 4'd6);
    check("b2b_done_low", 64'(done_o), 64'(0));
    check("b2b_hold", 64'(result_o), 64'(8'h06));
    wait_done(int'(W / 2) + 1);
    @(negedge clk);

    // Reset mid-op aborts without a done pulse
    launch(1'b1, 4'd14, 4'd4);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_busy", 64'(busy_o), 64'(0));
    check("abort_done", 64'(done_o), 64'(0));
    check("abort_result", 64'(result_o), 64'(0));
    check("abort_dbz", 64'(dbz_o), 64'(0));
    void'(sb.pop_back());
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    do_op(1'b1, 4'd14, 4'd4);

    // Random mix
    for (int i = 0; i < 10; i++) begin
      do_op(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 64'(sb.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
